ps2_scancode_rx: RTL
====================

Name: ps2_scancode_rx

Overview:
PS/2 keyboard receive stage that sits directly upstream of the VGA panel display. It deserialises the device-driven PS/2 clock/data pair into 8-bit scancodes and presents each good byte with a one-cycle valid strobe. It synchronises and deglitches the asynchronous PS/2 lines, checks framing and odd parity, and recovers from stalled partial frames by timeout.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before the filtered clock changes level (min 2).
TIMEOUT_CYCLES, 50000, clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
clk  input  1  system clock; all logic on posedge clk.
rst  input  1  reset; synchronous, active-high.
ps2_clk  input  1  PS/2 clock from device, asynchronous, idles high.
ps2_data  input  1  PS/2 data from device, asynchronous, idles high.
scancode  output  8  last good received byte; holds between frames.
valid  output  1  one-cycle strobe; scancode is new and stable on this cycle.
frame_err  output  1  one-cycle strobe on parity, stop-bit or timeout failure.

Behaviour:
- Reset (rst=1 at posedge clk): scancode=8'h00, valid=0, frame_err=0; FSM=IDLE; bit counter=0; synchroniser flops=1; filtered clock=1; filter and timeout counters=0. Reset mid-frame discards partial data; no strobe is issued.
- Sync: ps2_clk and ps2_data each pass through 2 flops. The data sample uses the synchronised data on the edge-detect cycle.
- Filter: counter increments while synced ps2_clk differs from filtered level, clears otherwise. Filtered level flips when the count reaches FILTER_LEN-1. A low pulse shorter than FILTER_LEN cycles produces no edge.
- Falling edge (fe) = filtered level 1->0, one-cycle pulse.
- FSM, advancing only on fe:
  - IDLE: data=0 (start) -> DATA, bit counter=0. Data=1 -> stay in IDLE, no error.
  - DATA: shreg <= {data, shreg[7:1]} (LSB first). After the 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: if data=1 and ^{shreg,parity}=1 (odd parity), scancode<=shreg and valid=1 on the next cycle. Otherwise frame_err=1 on the next cycle and scancode is unchanged. Both cases -> IDLE.
- Latency: valid/frame_err assert exactly 1 clk after the fe cycle of the stop bit. Each lasts exactly 1 cycle. valid and frame_err are never high together.
- Timeout: counter clears on every fe and while in IDLE; increments otherwise. In a non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err for 1 cycle. Timeout and fe in the same cycle: fe wins and the counter clears.
- Back-to-back frames: the next start bit is accepted on the first fe after returning to IDLE; no dead cycles are required.
- Counter widths: $clog2 of the respective parameter; no wrap because counters saturate/clear as above.

Optional Feature:
BREAK_SUPPRESS_EN
- Defined: a good byte 8'hF0 sets break_pending and produces no valid. The next good byte clears break_pending and produces no valid, so only make codes reach the display. Any frame_err clears break_pending. rst clears break_pending. scancode does not update for suppressed bytes.
- Undefined: every good byte, including 8'hF0 and the following release code, is emitted with valid.

Test Plan:
- Good frame 8'h1C, parity 0, stop 1, PS/2 clk 12.5 kHz -> valid high for exactly 1 cycle, 1 clk after stop fe; scancode=8'h1C; frame_err stays 0.
- Frame 8'h1C with parity bit forced to 1 -> frame_err 1-cycle pulse, valid stays 0, scancode keeps its prior value (8'h00 after reset). Repeat with stop bit 0 -> same response.
- Start bit plus 3 data bits, then ps2_clk held high -> frame_err pulse TIMEOUT_CYCLES cycles after the last fe. A following full frame 8'h45 -> valid with scancode=8'h45.
- Glitches: ps2_clk low pulses of FILTER_LEN-1 cycles inserted during a frame of 8'h29 -> no extra bits consumed; scancode=8'h29, valid once.
- Bytes 8'hF0 then 8'h1C back-to-back: macro defined -> no valid, scancode unchanged; macro undefined -> two valid pulses carrying 8'hF0 then 8'h1C.
- rst asserted for 1 cycle after 5 data bits of a frame -> all outputs return to reset values, no strobe. The next complete frame 8'h16 is received correctly.

Source files
------------

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: received-scancode bus from the PS/2 receive stage.
// master drives scancode/valid/frame_err; slave (display side) observes.
interface ps2_scancode_rx_if;
  logic [7:0] scancode;
  logic       valid;
  logic       frame_err;

  modport master (
    output scancode,
    output valid,
    output frame_err
  );

  modport slave (
    input scancode,
    input valid,
    input frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver. Syncs and deglitches ps2_clk,
// shifts 11-bit frames LSB first, checks odd parity and stop bit, and
// abandons stalled partial frames after TIMEOUT_CYCLES clk cycles.
// Ports: clk, rst (sync, active-high), ps2_clk, ps2_data (async inputs),
//   rx (master): scancode (last good byte), valid, frame_err (1-cycle strobes).
// Option: define BREAK_SUPPRESS_EN to swallow F0 break prefixes and the
//   release code that follows, so only make codes are presented.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_scancode_rx_if.master  rx
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;
  logic          filt_lvl;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fe;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          good;

`ifdef BREAK_SUPPRESS_EN
  logic          brk;
`endif

  // Two-flop synchronisers, then a run-length filter on the clock line:
  // the filtered level only follows after FILTER_LEN disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      filt_prev <= filt_lvl;
      if (clk_s2 != filt_lvl) begin
        if (filt_cnt == FMAX) begin
          filt_lvl <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fe   = filt_prev & ~filt_lvl;
  assign good = dat_s2 & (^{shreg, par});

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      to_cnt       <= '0;
      rx.scancode  <= '0;
      rx.valid     <= 1'b0;
      rx.frame_err <= 1'b0;
`ifdef BREAK_SUPPRESS_EN
      brk          <= 1'b0;
`endif
    end else begin
      rx.valid     <= 1'b0;
      rx.frame_err <= 1'b0;

      if (fe || state == S_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt != TMAX) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (fe) begin
        unique case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg <= {dat_s2, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= S_PAR;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_PAR: begin
            par   <= dat_s2;
            state <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
`ifdef BREAK_SUPPRESS_EN
            if (!good) begin
              rx.frame_err <= 1'b1;
              brk          <= 1'b0;
            end else if (brk) begin
              brk <= 1'b0;
            end else if (shreg == 8'hF0) begin
              brk <= 1'b1;
            end else begin
              rx.scancode <= shreg;
              rx.valid    <= 1'b1;
            end
`else
            if (good) begin
              rx.scancode <= shreg;
              rx.valid    <= 1'b1;
            end else begin
              rx.frame_err <= 1'b1;
            end
`endif
          end
        endcase
      end else if (state != S_IDLE && to_cnt == TMAX) begin
        // Device stopped clocking mid-frame: drop the partial byte.
        state        <= S_IDLE;
        rx.frame_err <= 1'b1;
`ifdef BREAK_SUPPRESS_EN
        brk          <= 1'b0;
`endif
      end
    end
  end

endmodule
